// File: rtl/tw_gen_if.sv
// Twiddle generator control and stream bundle.
// master = sequencer/consumer side, slave = tw_gen.
interface tw_gen_if #(
    parameter int N_FFT = 64,
    parameter int TW_W  = 9
);
    localparam int LOG2N = $clog2(N_FFT);

    logic                   start;
    logic [LOG2N-1:0]       stage;
    logic                   inv;
    logic                   busy;
    logic                   cfg_err;
    logic                   tw_valid;
    logic                   tw_ready;
    logic signed [TW_W-1:0] tw_re;
    logic signed [TW_W-1:0] tw_im;
    logic [LOG2N-2:0]       tw_idx;
    logic                   tw_last;

    modport master (
        output start, stage, inv, tw_ready,
        input  busy, cfg_err, tw_valid, tw_re, tw_im, tw_idx, tw_last
    );

    modport slave (
        input  start, stage, inv, tw_ready,
        output busy, cfg_err, tw_valid, tw_re, tw_im, tw_idx, tw_last
    );
endinterface

// File: rtl/tw_gen.sv
// Radix-2 DIF twiddle streamer: quarter-wave cosine ROM, 2-stage stallable
// pipeline (decode -> ROM read + sign), optional conjugate for IFFT.
module tw_gen #(
    parameter int N_FFT = 64,
    parameter int TW_W  = 9
) (
    input  logic    clk,
    input  logic    rst,
    tw_gen_if.slave tw
);
    localparam int LOG2N  = $clog2(N_FFT);
    localparam int JW     = LOG2N - 1;
    localparam int Q      = N_FFT / 4;
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // Magnitude-only table; signs are applied after the read.
    function automatic logic [TW_W-2:0] cos_q(input int i);
        real x;
        x = $cos(2.0 * 3.14159265358979323846 * real'(i) / real'(N_FFT))
            * real'(2 ** (TW_W - 2));
        return (TW_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [TW_W-2:0] rom [Q+1];
    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom[g] = cos_q(g);
    end

    state_t           st;
    logic [JW-1:0]    j;
    logic [LOG2N-1:0] s_r;
    logic             inv_r;
    logic             busy_r, cfg_err_r;

    logic [STAGES:1]  vld_pipe;
    logic [JW-1:0]    ra1, ia1, idx1;
    logic             nre1, nim1, last1;
    logic signed [TW_W-1:0] re2, im2;
    logic [JW-1:0]    idx2;
    logic             last2;

    logic             stage_ok, go, adv, issue;
    logic [JW-1:0]    j_i;
    logic [LOG2N-1:0] s_i;
    logic             inv_i;
    logic [JW-1:0]    ra_d, ia_d;
    logic             nre_d, nim_d, last_d;
    logic signed [TW_W-1:0] mr, mi;

    // Everything freezes while a presented beat is refused.
    assign adv      = !(vld_pipe[2] && !tw.tw_ready);
    assign stage_ok = int'(tw.stage) < LOG2N;
    assign go       = (st == IDLE) && tw.start && stage_ok;
    assign issue    = go || ((st == RUN) && adv);

    // Beat 0 is issued straight from the start cycle so valid lands at start+2.
    assign j_i   = (st == IDLE) ? '0 : j;
    assign s_i   = (st == IDLE) ? tw.stage : s_r;
    assign inv_i = (st == IDLE) ? tw.inv : inv_r;

    always_comb begin
        int mask, k;
        mask  = ((N_FFT / 2) >> s_i) - 1;
        k     = (int'(j_i) & mask) << s_i;
        ra_d  = '0;
        ia_d  = '0;
        nre_d = 1'b0;
        if (k <= Q) begin
            ra_d = JW'(k);
            ia_d = JW'(Q - k);
        end else begin
            ra_d  = JW'(N_FFT / 2 - k);
            ia_d  = JW'(k - Q);
            nre_d = 1'b1;
        end
        nim_d  = !inv_i;
        last_d = (j_i == JW'(N_FFT / 2 - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            j         <= '0;
            s_r       <= '0;
            inv_r     <= 1'b0;
            busy_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= (st == IDLE) && tw.start && !stage_ok;
            case (st)
                IDLE: if (go) begin
                    st     <= RUN;
                    j      <= JW'(1);
                    s_r    <= tw.stage;
                    inv_r  <= tw.inv;
                    busy_r <= 1'b1;
                end
                RUN: if (adv) begin
                    if (j == JW'(N_FFT / 2 - 1)) st <= FLUSH;
                    else                         j  <= j + 1'b1;
                end
                FLUSH: if (vld_pipe[2] && tw.tw_ready && last2) begin
                    st     <= IDLE;
                    busy_r <= 1'b0;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign mr = signed'({1'b0, rom[ra1]});
    assign mi = signed'({1'b0, rom[ia1]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            ra1      <= '0;
            ia1      <= '0;
            idx1     <= '0;
            nre1     <= 1'b0;
            nim1     <= 1'b0;
            last1    <= 1'b0;
            re2      <= '0;
            im2      <= '0;
            idx2     <= '0;
            last2    <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[1], issue};
            if (issue) begin
                ra1   <= ra_d;
                ia1   <= ia_d;
                idx1  <= j_i;
                nre1  <= nre_d;
                nim1  <= nim_d;
                last1 <= last_d;
            end
            last2 <= vld_pipe[1] && last1;
            if (vld_pipe[1]) begin
                re2  <= nre1 ? -mr : mr;
                im2  <= nim1 ? -mi : mi;
                idx2 <= idx1;
            end
        end
    end

    assign tw.busy     = busy_r;
    assign tw.cfg_err  = cfg_err_r;
    assign tw.tw_valid = vld_pipe[2];
    assign tw.tw_re    = re2;
    assign tw.tw_im    = im2;
    assign tw.tw_idx   = idx2;
    assign tw.tw_last  = last2;
endmodule

// File: tb/tb_tw_gen.sv
// Scoreboard bench for tw_gen at N_FFT=64, TW_W=9.
module tb_tw_gen;
    localparam int N     = 64;
    localparam int W     = 9;
    localparam int LOG2N = 6;
    localparam real PI   = 3.14159265358979323846;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    tw_gen_if #(.N_FFT(N), .TW_W(W)) tif ();

    tw_gen #(.N_FFT(N), .TW_W(W)) dut (.clk(clk), .rst(rst), .tw(tif));

    always #5 clk = ~clk;

    int    vecs = 0, errs = 0;
    int    cyc = 0;
    int    start_cyc, seq_id = 0, seen_id = 0;
    int    last_idx = -1;
    beat_t sbq[$];
    int    cap_re[N/2], cap_im[N/2];
    bit    hold_v = 1'b0;
    int    h_re, h_im, h_idx, h_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic beat_t model(input int s, input bit inv, input int j);
        beat_t b;
        int  k;
        real a;
        k      = (j % ((N / 2) >> s)) << s;
        a      = 2.0 * PI * real'(k) / real'(N);
        b.re   = rnd($cos(a) * 128.0);
        b.im   = -rnd($sin(a) * 128.0);
        if (inv) b.im = -b.im;
        b.idx  = j;
        b.last = (j == N / 2 - 1) ? 1 : 0;
        return b;
    endfunction

    // Monitor: scoreboard compare, latency of first beat, stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_v) begin
                chk("stall_vld",  int'(tif.tw_valid), 1);
                chk("stall_re",   int'(tif.tw_re), h_re);
                chk("stall_im",   int'(tif.tw_im), h_im);
                chk("stall_idx",  int'(tif.tw_idx), h_idx);
                chk("stall_last", int'(tif.tw_last), h_last);
            end
            if (tif.tw_valid && seen_id != seq_id) begin
                chk("first_lat", cyc - start_cyc, 2);
                seen_id = seq_id;
            end
            if (tif.tw_valid && tif.tw_ready) begin
                if (sbq.size() == 0) begin
                    chk("extra_beat", int'(tif.tw_idx), -1);
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    chk("re",   int'(tif.tw_re), e.re);
                    chk("im",   int'(tif.tw_im), e.im);
                    chk("idx",  int'(tif.tw_idx), e.idx);
                    chk("last", int'(tif.tw_last), e.last);
                    cap_re[tif.tw_idx] = int'(tif.tw_re);
                    cap_im[tif.tw_idx] = int'(tif.tw_im);
                    last_idx = int'(tif.tw_idx);
                end
            end
            hold_v = tif.tw_valid && !tif.tw_ready;
            h_re   = int'(tif.tw_re);
            h_im   = int'(tif.tw_im);
            h_idx  = int'(tif.tw_idx);
            h_last = int'(tif.tw_last);
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic start_seq(input int s, input bit inv);
        tif.start = 1'b1;
        tif.stage = LOG2N'(s);
        tif.inv   = inv;
        if (s < LOG2N) begin
            for (int j = 0; j < N / 2; j++) sbq.push_back(model(s, inv, j));
            start_cyc = cyc;
            seq_id++;
        end
        @(posedge clk); #1;
        tif.start = 1'b0;
    endtask

    // Returns in the first cycle busy is low, so a following start is back-to-back.
    task automatic wait_idle(input bit rnd_ready);
        int n = 0;
        do begin
            @(posedge clk); #1;
            if (rnd_ready) tif.tw_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!(!tif.busy && sbq.size() == 0) && n < 3000);
        if (n >= 3000) chk("idle_timeout", n, 0);
        tif.tw_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        tif.start    = 1'b0;
        tif.stage    = '0;
        tif.inv      = 1'b0;
        tif.tw_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  int'(tif.busy), 0);
        chk("rst_err",   int'(tif.cfg_err), 0);
        chk("rst_valid", int'(tif.tw_valid), 0);
        chk("rst_last",  int'(tif.tw_last), 0);
        chk("rst_re",    int'(tif.tw_re), 0);
        chk("rst_im",    int'(tif.tw_im), 0);
        chk("rst_idx",   int'(tif.tw_idx), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Stage 0 forward, known points on the unit circle.
        start_seq(0, 1'b0);
        wait_idle(1'b0);
        chk("s0_j0_re",  cap_re[0], 128);  chk("s0_j0_im",  cap_im[0], 0);
        chk("s0_j8_re",  cap_re[8], 91);   chk("s0_j8_im",  cap_im[8], -91);
        chk("s0_j16_re", cap_re[16], 0);   chk("s0_j16_im", cap_im[16], -128);
        chk("s0_j24_re", cap_re[24], -91); chk("s0_j24_im", cap_im[24], -91);

        // Later stages, started back-to-back.
        start_seq(4, 1'b0);
        wait_idle(1'b0);
        chk("s4_j30_re", cap_re[30], 128); chk("s4_j30_im", cap_im[30], 0);
        chk("s4_j31_re", cap_re[31], 0);   chk("s4_j31_im", cap_im[31], -128);
        start_seq(5, 1'b0);
        wait_idle(1'b0);
        chk("s5_j17_re", cap_re[17], 128); chk("s5_j17_im", cap_im[17], 0);

        // Inverse mode conjugates.
        start_seq(0, 1'b1);
        wait_idle(1'b0);
        chk("inv_j16_re", cap_re[16], 0);   chk("inv_j16_im", cap_im[16], 128);
        chk("inv_j8_re",  cap_re[8], 91);   chk("inv_j8_im",  cap_im[8], 91);
        chk("inv_j24_re", cap_re[24], -91); chk("inv_j24_im", cap_im[24], 91);

        // Random backpressure.
        start_seq(1, 1'b0);
        wait_idle(1'b1);
        start_seq(3, 1'b1);
        wait_idle(1'b1);

        // Bad stage in idle.
        @(posedge clk); #1;
        tif.start = 1'b1;
        tif.stage = 6'd6;
        @(posedge clk); #1;
        tif.start = 1'b0;
        chk("cfg_err_hi",   int'(tif.cfg_err), 1);
        chk("cfg_err_busy", int'(tif.busy), 0);
        @(posedge clk); #1;
        chk("cfg_err_lo",    int'(tif.cfg_err), 0);
        chk("cfg_err_busy2", int'(tif.busy), 0);

        // Starts while busy are ignored, including a bad stage.
        start_seq(2, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        tif.start = 1'b1;
        tif.stage = 6'd3;
        tif.inv   = 1'b1;
        @(posedge clk); #1;
        tif.stage = 6'd7;
        @(posedge clk); #1;
        tif.start = 1'b0;
        chk("busy_start_err",  int'(tif.cfg_err), 0);
        chk("busy_start_busy", int'(tif.busy), 1);
        wait_idle(1'b0);

        // Reset mid-sequence, then a clean restart.
        start_seq(0, 1'b0);
        begin
            int n = 0;
            while (last_idx != 10 && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) chk("wait_j10_timeout", n, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", int'(tif.tw_valid), 0);
        chk("abort_busy",  int'(tif.busy), 0);
        sbq.delete();
        @(posedge clk); #1;
        chk("abort_valid2", int'(tif.tw_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        start_seq(0, 1'b0);
        wait_idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
